// File: rtl/mmio_ctrl.sv
// Purpose: memory-mapped I/O decode between the cpu memory port, RAM, LED/HEX registers, switch port and an interval timer.
// Latency: reads are combinational (same cycle); writes and clear-on-read take effect at the next clk edge.
// Backpressure: none; every access completes in a single cycle, the block is always ready.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   mem_cmd/mem_addr       cpu command (10 read, 11 write, else idle) and address
//   write_data/read_data   cpu write data in, combinational read data out
//   ram_addr/ram_write     RAM address and write enable (RAM region is mem_addr MSB == 0)
//   ram_din/ram_dout       RAM write data out, RAM read data in
//   sw_in                  raw asynchronous switches (two-flop synchronised internally)
//   ledr, hex_data         LED and HEX register contents
//   tmr_irq                level copy of the sticky timer flag
module mmio_ctrl #(
    parameter int                ADDR_W        = 9,
    parameter int                DATA_W        = 16,
    parameter int                LED_W         = 8,
    parameter int                SW_W          = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR      = 9'h100,
    parameter logic [ADDR_W-1:0] HEX_ADDR      = 9'h120,
    parameter logic [ADDR_W-1:0] SW_ADDR       = 9'h140,
    parameter logic [ADDR_W-1:0] TMR_CMP_ADDR  = 9'h180,
    parameter logic [ADDR_W-1:0] TMR_CNT_ADDR  = 9'h181,
    parameter logic [ADDR_W-1:0] TMR_CTL_ADDR  = 9'h182,
    parameter logic [ADDR_W-1:0] TMR_STAT_ADDR = 9'h183,
    parameter int                PRESCALE      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-2:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  ledr,
    output logic [DATA_W-1:0] hex_data,
    output logic              tmr_irq
);

    localparam logic [1:0] CMD_RD = 2'b10;
    localparam logic [1:0] CMD_WR = 2'b11;
    // Keep the prescaler at least one bit wide so PRESCALE == 1 still elaborates.
    localparam int              PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    logic              is_rd;
    logic              is_wr;
    logic              ram_sel;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [DATA_W-1:0] tmr_cmp;
    logic [DATA_W-1:0] tmr_cnt;
    logic [PSC_W-1:0]  tmr_psc;
    logic              tmr_en;
    logic              tmr_flag;
    logic              tmr_tick;
    logic              tmr_match;
    logic              stat_rd;

    assign is_rd     = (mem_cmd == CMD_RD);
    assign is_wr     = (mem_cmd == CMD_WR);
    assign ram_sel   = ~mem_addr[ADDR_W-1];
    assign ram_write = is_wr & ram_sel;
    assign ram_addr  = mem_addr[ADDR_W-2:0];
    assign ram_din   = write_data;
    assign tmr_irq   = tmr_flag;

    assign tmr_tick  = tmr_en && (tmr_psc == PSC_MAX);
    assign tmr_match = tmr_tick && (tmr_cnt == tmr_cmp);
    assign stat_rd   = is_rd && (mem_addr == TMR_STAT_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            ledr     <= '0;
            hex_data <= '0;
            tmr_cmp  <= '0;
            tmr_cnt  <= '0;
            tmr_psc  <= '0;
            tmr_en   <= 1'b0;
            tmr_flag <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;

            if (is_wr && mem_addr == LED_ADDR)     ledr     <= write_data[LED_W-1:0];
            if (is_wr && mem_addr == HEX_ADDR)     hex_data <= write_data;
            if (is_wr && mem_addr == TMR_CMP_ADDR) tmr_cmp  <= write_data;
            if (is_wr && mem_addr == TMR_CTL_ADDR) tmr_en   <= write_data[0];

            // Prescaler and count freeze while disabled; re-enabling resumes from where they stopped.
            if (tmr_en) begin
                tmr_psc <= tmr_tick ? '0 : tmr_psc + 1'b1;
            end
            if (tmr_tick) begin
                tmr_cnt <= tmr_match ? '0 : tmr_cnt + 1'b1;
            end

            // A match in the same cycle as a status read keeps the flag set so no event is lost.
            if (tmr_match) begin
                tmr_flag <= 1'b1;
            end else if (stat_rd) begin
                tmr_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (is_rd) begin
            if (ram_sel) begin
                read_data = ram_dout;
            end else if (mem_addr == HEX_ADDR) begin
                read_data = hex_data;
            end else if (mem_addr == SW_ADDR) begin
                read_data = DATA_W'(sw_sync);
            end else if (mem_addr == TMR_CMP_ADDR) begin
                read_data = tmr_cmp;
            end else if (mem_addr == TMR_CNT_ADDR) begin
                read_data = tmr_cnt;
            end else if (mem_addr == TMR_CTL_ADDR) begin
                read_data = DATA_W'(tmr_en);
            end else if (mem_addr == TMR_STAT_ADDR) begin
                read_data = DATA_W'(tmr_flag);
            end
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Purpose: self-checking bench for mmio_ctrl with a reference model and directed accesses.
// Latency: model follows the access rules directly; outputs compared every negedge after reset.
// Backpressure: not applicable; stimulus is one access per cycle.
module tb_mmio_ctrl;

    localparam int PRESCALE = 4;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b11;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  sw_in;
    logic [7:0]  ledr;
    logic [15:0] hex_data;
    logic        tmr_irq;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data), .ram_addr(ram_addr),
        .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
        .sw_in(sw_in), .ledr(ledr), .hex_data(hex_data), .tmr_irq(tmr_irq)
    );

    // Simple RAM stand-in: data is a recognisable function of the address.
    assign ram_dout = {8'hA5, ram_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_led;
    logic [15:0] m_hex, m_cmp, m_cnt;
    logic        m_en, m_flag, m_valid;
    logic [7:0]  sw_hist [0:1];
    int          en_cycles;
    logic        m_tick, m_match;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_led = '0; m_hex = '0; m_cmp = '0; m_cnt = '0;
            m_en = 1'b0; m_flag = 1'b0; en_cycles = 0;
            sw_hist[0] = '0; sw_hist[1] = '0;
            m_valid = 1'b1;
        end else begin
            // One tick every PRESCALE enabled cycles, on the last cycle of each group.
            m_tick  = m_en && ((en_cycles % PRESCALE) == PRESCALE - 1);
            m_match = m_tick && (m_cnt == m_cmp);
            if (m_en) en_cycles++;
            if (m_tick) m_cnt = m_match ? 16'd0 : m_cnt + 16'd1;
            if (m_match) m_flag = 1'b1;
            else if (mem_cmd == RD && mem_addr == 9'h183) m_flag = 1'b0;
            if (mem_cmd == WR) begin
                case (mem_addr)
                    9'h100:  m_led = write_data[7:0];
                    9'h120:  m_hex = write_data;
                    9'h180:  m_cmp = write_data;
                    9'h182:  m_en  = write_data[0];
                    default: ;
                endcase
            end
            sw_hist[1] = sw_hist[0];
            sw_hist[0] = sw_in;
        end
    end

    function automatic logic [15:0] exp_read();
        if (mem_cmd != RD) return 16'h0;
        if (!mem_addr[8]) return {8'hA5, mem_addr[7:0]};
        case (mem_addr)
            9'h120:  return m_hex;
            9'h140:  return {8'h00, sw_hist[1]};
            9'h180:  return m_cmp;
            9'h181:  return m_cnt;
            9'h182:  return {15'h0, m_en};
            9'h183:  return {15'h0, m_flag};
            default: return 16'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("read_data", read_data, exp_read());
            check("ledr", ledr, m_led);
            check("hex_data", hex_data, m_hex);
            check("tmr_irq", tmr_irq, m_flag);
            check("ram_write", ram_write, (mem_cmd == WR) && !mem_addr[8]);
            check("ram_addr", ram_addr, mem_addr[7:0]);
            check("ram_din", ram_din, write_data);
        end
    end

    // ---------------- directed stimulus ----------------
    // Called just after a posedge; presents one access for one cycle.
    task automatic op(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic rw);
        mem_cmd = c; mem_addr = a; write_data = d;
        #3;
        rd = read_data;
        rw = ram_write;
        @(posedge clk);
        #1;
        mem_cmd = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] rd;
    logic        rw;
    logic [8:0]  per_addr [0:6];

    initial begin
        reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw_in = '0;
        per_addr[0] = 9'h100; per_addr[1] = 9'h120; per_addr[2] = 9'h140; per_addr[3] = 9'h180;
        per_addr[4] = 9'h181; per_addr[5] = 9'h182; per_addr[6] = 9'h183;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_ledr", ledr, 8'h00);
        check("rst_hex", hex_data, 16'h0000);
        check("rst_irq", tmr_irq, 1'b0);
        for (int i = 0; i < 7; i++) begin
            op(RD, per_addr[i], 16'h0, rd, rw);
            check("rst_read", rd, 16'h0000);
        end

        // Register and RAM writes
        op(WR, 9'h100, 16'hABCD, rd, rw);
        check("wr_led_ramwr", rw, 1'b0);
        check("wr_led", ledr, 8'hCD);
        op(WR, 9'h120, 16'h1234, rd, rw);
        check("wr_hex", hex_data, 16'h1234);
        op(WR, 9'h040, 16'h5555, rd, rw);
        check("wr_ram_ramwr", rw, 1'b1);
        op(RD, 9'h100, 16'h0, rd, rw);
        check("rd_led_zero", rd, 16'h0000);
        op(RD, 9'h120, 16'h0, rd, rw);
        check("rd_hex", rd, 16'h1234);
        op(RD, 9'h040, 16'h0, rd, rw);
        check("rd_ram", rd, 16'hA540);
        op(2'b01, 9'h120, 16'h0, rd, rw);
        check("cmd01_read", rd, 16'h0000);
        op(2'b01, 9'h100, 16'h0011, rd, rw);
        check("cmd01_nowrite", ledr, 8'hCD);

        // Switch synchroniser: visible at the second edge after the change
        sw_in = 8'h5A;
        op(RD, 9'h140, 16'h0, rd, rw);
        check("sw_edge0", rd, 16'h0000);
        op(RD, 9'h140, 16'h0, rd, rw);
        check("sw_edge1", rd, 16'h0000);
        op(RD, 9'h140, 16'h0, rd, rw);
        check("sw_edge2", rd, 16'h005A);
        op(WR, 9'h140, 16'hFFFF, rd, rw);
        op(RD, 9'h140, 16'h0, rd, rw);
        check("sw_ro", rd, 16'h005A);

        // Timer: compare 3, prescale 4 -> flag 16 clocks after enable
        op(WR, 9'h180, 16'd3, rd, rw);
        op(WR, 9'h182, 16'd1, rd, rw);
        idle(15);
        check("tmr_pre_irq", tmr_irq, 1'b0);
        op(RD, 9'h181, 16'h0, rd, rw);
        check("tmr_cnt3", rd, 16'd3);
        check("tmr_irq_rise", tmr_irq, 1'b1);
        op(RD, 9'h181, 16'h0, rd, rw);
        check("tmr_cnt0", rd, 16'd0);
        op(RD, 9'h183, 16'h0, rd, rw);
        check("stat_rd1", rd, 16'd1);
        check("irq_cleared", tmr_irq, 1'b0);
        op(RD, 9'h183, 16'h0, rd, rw);
        check("stat_rd0", rd, 16'd0);

        // Status read on the same edge as a match: set wins
        idle(12);
        op(RD, 9'h183, 16'h0, rd, rw);
        check("coll_old", rd, 16'd0);
        check("coll_irq", tmr_irq, 1'b1);
        op(WR, 9'h182, 16'd1, rd, rw);

        // compare = 0: flag on every tick
        op(WR, 9'h180, 16'd0, rd, rw);
        op(RD, 9'h183, 16'h0, rd, rw);
        check("cmp0_clr", rd, 16'd1);
        check("cmp0_irq_lo", tmr_irq, 1'b0);
        idle(1);
        check("cmp0_tick1", tmr_irq, 1'b1);
        op(RD, 9'h181, 16'h0, rd, rw);
        check("cmp0_cnt", rd, 16'd0);
        op(RD, 9'h183, 16'h0, rd, rw);
        check("cmp0_clr2", rd, 16'd1);
        idle(2);
        check("cmp0_tick2", tmr_irq, 1'b1);

        // Reset beats a same-cycle write
        reset = 1'b1;
        op(WR, 9'h120, 16'hBEEF, rd, rw);
        reset = 1'b0;
        check("rst2_hex", hex_data, 16'h0000);
        check("rst2_irq", tmr_irq, 1'b0);
        check("rst2_led", ledr, 8'h00);
        op(RD, 9'h182, 16'h0, rd, rw);
        check("rst2_en", rd, 16'd0);
        op(RD, 9'h180, 16'h0, rd, rw);
        check("rst2_cmp", rd, 16'd0);
        idle(8);
        op(RD, 9'h181, 16'h0, rd, rw);
        check("rst2_cnt_hold", rd, 16'd0);
        op(RD, 9'h183, 16'h0, rd, rw);
        check("rst2_flag", rd, 16'd0);
        op(RD, 9'h140, 16'h0, rd, rw);
        check("rst2_sw", rd, 16'h005A);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
